// File: rtl/sorting_pkt_tx.sv
// Packet transmitter feeding the sorter: buffers one upstream packet, then
// emits it as a gap-free val/sop/eop burst once the sorter is idle.
module sorting_pkt_tx #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 3
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] in_data_i,
   input  logic              in_val_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o,
   input  logic              busy_i,
   output logic              drop_o,
   output logic [15:0]       pkt_cnt_o
);

   localparam int unsigned DEPTH  = 2 ** AWIDTH;
   localparam int unsigned LWIDTH = AWIDTH + 1;
   localparam int unsigned GWIDTH = 2;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LWIDTH-1:0]   len_q, len_d;
   logic [GWIDTH-1:0]   guard_q, guard_d;
   logic [DWIDTH-1:0]   data_d;
   logic                sop_d, eop_d, val_d, drop_d;
   logic [15:0]         pkt_cnt_d;
   logic [DWIDTH-1:0]   mem_q [DEPTH];
   logic                wr_en;
   logic                full_word;

   // Reset is excluded from the internal write enable; it only gates the port.
   assign wr_en      = (state_q == ST_FILL) && in_val_i;
   assign full_word  = (wr_ptr_q == AWIDTH'(DEPTH - 1));
   assign in_ready_o = (state_q == ST_FILL) && !srst_i;

   // Packet buffer; stale contents are never read because len gates the burst.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state_q <= ST_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counters and next values of the registered outputs.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      len_d     = len_q;
      guard_d   = (guard_q != '0) ? guard_q - GWIDTH'(1) : guard_q;
      data_d    = data_o;
      sop_d     = 1'b0;
      eop_d     = 1'b0;
      val_d     = 1'b0;
      drop_d    = 1'b0;
      pkt_cnt_d = pkt_cnt_o;

      unique case (state_q)
         ST_FILL: begin
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + AWIDTH'(1);
               // A last flag on the full word is the same single close.
               if (in_last_i || full_word) begin
                  if (wr_ptr_q == '0) begin
                     drop_d   = 1'b1;
                     wr_ptr_d = '0;
                  end else begin
                     len_d   = LWIDTH'(wr_ptr_q) + LWIDTH'(1);
                     state_d = ST_WAIT;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (!busy_i && (guard_q == '0)) begin
               state_d  = ST_SEND;
               val_d    = 1'b1;
               sop_d    = 1'b1;
               data_d   = mem_q[0];
               rd_ptr_d = AWIDTH'(1);
            end
         end
         ST_SEND: begin
            if (eop_o) begin
               state_d   = ST_FILL;
               pkt_cnt_d = pkt_cnt_o + 16'd1;
               guard_d   = GWIDTH'(2);
               wr_ptr_d  = '0;
            end else begin
               val_d    = 1'b1;
               data_d   = mem_q[rd_ptr_q];
               eop_d    = (LWIDTH'(rd_ptr_q) == (len_q - LWIDTH'(1)));
               rd_ptr_d = rd_ptr_q + AWIDTH'(1);
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         len_q     <= '0;
         guard_q   <= '0;
         data_o    <= '0;
         sop_o     <= 1'b0;
         eop_o     <= 1'b0;
         val_o     <= 1'b0;
         drop_o    <= 1'b0;
         pkt_cnt_o <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         len_q     <= len_d;
         guard_q   <= guard_d;
         data_o    <= data_d;
         sop_o     <= sop_d;
         eop_o     <= eop_d;
         val_o     <= val_d;
         drop_o    <= drop_d;
         pkt_cnt_o <= pkt_cnt_d;
      end
   end

endmodule

// File: tb/tb_sorting_pkt_tx.sv
// Scoreboard bench for sorting_pkt_tx: the driver queues expected burst words,
// a negedge monitor pops and compares whatever the DUT emits.
module tb_sorting_pkt_tx;

   typedef struct {
      logic [7:0] d;
      bit         sop;
      bit         eop;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       srst_i;
   logic [7:0] in_data_i;
   logic       in_val_i;
   logic       in_last_i;
   logic       in_ready_o;
   logic [7:0] data_o;
   logic       sop_o, eop_o, val_o;
   logic       busy_i;
   logic       drop_o;
   logic [15:0] pkt_cnt_o;

   logic busy_dir  = 1'b0;
   logic busy_rand = 1'b0;
   bit   rand_mode = 1'b0;
   assign busy_i = rand_mode ? busy_rand : busy_dir;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   exp_drops  = 0;
   int   drops_seen = 0;
   int   mcnt = 0;
   bit   chk_cnt = 1'b0;
   bit   in_burst = 1'b0;
   bit   have_eop = 1'b0;
   int   cyc = 0;
   int   last_eop_cyc = 0;
   logic busy_prev = 1'b0;
   logic [7:0] pkt_buf [8];

   sorting_pkt_tx #(.DWIDTH(8), .AWIDTH(3)) dut (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .in_data_i (in_data_i),
      .in_val_i  (in_val_i),
      .in_last_i (in_last_i),
      .in_ready_o(in_ready_o),
      .data_o    (data_o),
      .sop_o     (sop_o),
      .eop_o     (eop_o),
      .val_o     (val_o),
      .busy_i    (busy_i),
      .drop_o    (drop_o),
      .pkt_cnt_o (pkt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_true(input string nm, input bit ok, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Busy as seen by the DUT at each active edge.
   always @(posedge clk_i) busy_prev <= busy_i;

   // Random busy generator for the soak phase.
   initial begin
      forever begin
         @(negedge clk_i);
         busy_rand = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: pops expected burst words and checks framing, timing and count.
   always @(negedge clk_i) begin
      exp_t e;
      if (!srst_i) begin
         cyc++;
         if (chk_cnt) begin
            chk("pkt_cnt", 32'(pkt_cnt_o), 32'(mcnt));
            chk_cnt = 1'b0;
         end
         if (drop_o) drops_seen++;
         if (val_o) begin
            if (exp_q.size() == 0) begin
               chk_true("unexpected_val", 1'b0, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("data", 32'(data_o), 32'(e.d));
               chk("sop", 32'(sop_o), 32'(e.sop));
               chk("eop", 32'(eop_o), 32'(e.eop));
               if (e.sop) begin
                  chk("sop_while_busy", 32'(busy_prev), 32'd0);
                  if (have_eop)
                     chk_true("eop_to_sop_gap", (cyc - last_eop_cyc) >= 3,
                              cyc - last_eop_cyc, 3);
                  in_burst = 1'b1;
               end
               if (e.eop) begin
                  in_burst     = 1'b0;
                  mcnt         = (mcnt + 1) % 65536;
                  chk_cnt      = 1'b1;
                  have_eop     = 1'b1;
                  last_eop_cyc = cyc;
               end
            end
         end else if (in_burst) begin
            chk_true("burst_gap", 1'b0, 0, 1);
            in_burst = 1'b0;
         end
      end
   end

   // Queue the expected result, then hand the packet over the upstream stream.
   task automatic send_words(input int n, input bit set_last, input bit bubbles);
      int c;
      if (n == 1) begin
         exp_drops++;
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d   = pkt_buf[i];
            e.sop = (i == 0);
            e.eop = (i == n - 1);
            exp_q.push_back(e);
         end
      end
      for (int i = 0; i < n; i++) begin
         if (bubbles && ($urandom_range(0, 3) == 0)) begin
            in_val_i = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk_i);
         end
         in_val_i  = 1'b1;
         in_data_i = pkt_buf[i];
         in_last_i = set_last && (i == n - 1);
         c = 0;
         while (!in_ready_o && c < 500) begin
            @(negedge clk_i);
            c++;
         end
         if (!in_ready_o) chk_true("ready_timeout", 1'b0, c, 500);
         @(negedge clk_i);
      end
      in_val_i  = 1'b0;
      in_last_i = 1'b0;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk_i);
         c++;
      end
      repeat (2) @(negedge clk_i);
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_sop(input int budget);
      int c = 0;
      while (!sop_o && c < budget) begin
         @(negedge clk_i);
         c++;
      end
      chk("sop_seen", 32'(sop_o), 32'd1);
   endtask

   initial begin
      int n;
      bit lst;
      srst_i    = 1'b1;
      in_val_i  = 1'b0;
      in_last_i = 1'b0;
      in_data_i = '0;
      #1;
      chk("rst_ready", 32'(in_ready_o), 32'd0);
      chk("rst_val", 32'(val_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_drop", 32'(drop_o), 32'd0);
      chk("rst_cnt", 32'(pkt_cnt_o), 32'd0);
      repeat (3) @(negedge clk_i);
      srst_i = 1'b0;
      #1;
      chk("ready_after_rst", 32'(in_ready_o), 32'd1);
      @(negedge clk_i);

      // 3-word packet
      pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33;
      send_words(3, 1'b1, 1'b0);
      drain(50);
      chk("cnt_after_first", 32'(pkt_cnt_o), 32'd1);

      // Close on full, no last flag
      for (int i = 0; i < 8; i++) pkt_buf[i] = 8'(i);
      send_words(8, 1'b0, 1'b0);
      chk("ready_drops_at_full", 32'(in_ready_o), 32'd0);
      drain(50);

      // Busy held high while the packet waits
      busy_dir = 1'b1;
      pkt_buf[0] = 8'hA1; pkt_buf[1] = 8'hB2; pkt_buf[2] = 8'hC3;
      send_words(3, 1'b1, 1'b0);
      repeat (20) begin
         @(negedge clk_i);
         chk("val_while_busy", 32'(val_o), 32'd0);
      end
      busy_dir = 1'b0;
      @(negedge clk_i);
      chk("sop_after_busy_low", 32'(sop_o), 32'd1);
      drain(50);

      // Single-word drop, then a 2-word packet
      pkt_buf[0] = 8'h5A;
      send_words(1, 1'b1, 1'b0);
      chk("drop_pulse", 32'(drop_o), 32'd1);
      @(negedge clk_i);
      chk("drop_one_cycle", 32'(drop_o), 32'd0);
      chk("cnt_after_drop", 32'(pkt_cnt_o), 32'd3);
      pkt_buf[0] = 8'h01; pkt_buf[1] = 8'h02;
      send_words(2, 1'b1, 1'b0);
      drain(50);

      // Back-to-back packets; busy rises during the second burst
      for (int i = 0; i < 4; i++) pkt_buf[i] = 8'h40 + 8'(i);
      send_words(4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) pkt_buf[i] = 8'h70 + 8'(i);
      send_words(3, 1'b1, 1'b0);
      wait_sop(100);
      busy_dir = 1'b1;
      drain(50);
      busy_dir = 1'b0;

      // Async reset during the second word of a 6-word burst
      for (int i = 0; i < 6; i++) pkt_buf[i] = 8'h90 + 8'(i);
      send_words(6, 1'b1, 1'b0);
      wait_sop(100);
      @(negedge clk_i);
      #2;
      srst_i = 1'b1;
      #1;
      chk("mid_rst_val", 32'(val_o), 32'd0);
      chk("mid_rst_sop", 32'(sop_o), 32'd0);
      chk("mid_rst_eop", 32'(eop_o), 32'd0);
      chk("mid_rst_data", 32'(data_o), 32'd0);
      chk("mid_rst_ready", 32'(in_ready_o), 32'd0);
      chk("mid_rst_cnt", 32'(pkt_cnt_o), 32'd0);
      exp_q.delete();
      in_burst = 1'b0;
      have_eop = 1'b0;
      chk_cnt  = 1'b0;
      mcnt     = 0;
      repeat (2) @(negedge clk_i);
      srst_i = 1'b0;
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) pkt_buf[i] = 8'hE0 + 8'(i);
      send_words(4, 1'b1, 1'b0);
      drain(50);
      chk("cnt_after_rst_pkt", 32'(pkt_cnt_o), 32'd1);

      // Random soak with random busy and upstream bubbles
      rand_mode = 1'b1;
      for (int p = 0; p < 100; p++) begin
         n = $urandom_range(2, 8);
         for (int i = 0; i < n; i++) pkt_buf[i] = 8'($urandom);
         lst = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         send_words(n, lst, 1'b1);
      end
      drain(2000);
      rand_mode = 1'b0;
      chk("drops", 32'(drops_seen), 32'(exp_drops));
      chk("final_cnt", 32'(pkt_cnt_o), 32'(mcnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if something stalls beyond every bounded wait.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
